fc_input_collector: RTL and testbench
=====================================

# fc_input_collector

Serial-to-parallel front end for the fully-connected classifier. Accepts the flattened feature map from the last convolution/pooling stage one 32-bit IEEE-754 word per handshake. Assembles N_WORDS words into the wide vector driving the FC stage's input bus, then pulses that stage's start/reset. The vector is held stable for a fixed FC_LATENCY window, after which frame_done marks the classifier outputs as valid and the next frame is accepted.

## Interface
- DATA_WIDTH, 32, width of one feature word (IEEE-754 single).
- N_WORDS, 120, words per frame; equals the FC stage input node count.
- FC_LATENCY, 1024, cycles from fc_start deassertion to frame_done; must be >= 1.
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high.
- in_data  input  DATA_WIDTH  feature word.
- in_valid  input  1  in_data valid.
- in_last  input  1  qualifies the final word of a frame; sampled only on accept.
- in_ready  output  1  collector can accept; combinational, equals (state == FILL).
- vec_out  output  N_WORDS*DATA_WIDTH  assembled frame; word i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- fc_start  output  1  registered one-cycle pulse; drives the FC stage's active-high reset/start.
- busy  output  1  registered; high in LAUNCH and WAIT.
- frame_done  output  1  registered one-cycle pulse; FC/softmax outputs valid.
- err_len  output  1  registered one-cycle pulse on a frame-length violation.

## Operation
- Accept = in_valid && in_ready. Both data and in_last are sampled on the rising edge where accept is true.
- States:
  - FILL: in_ready=1. Each accept writes in_data into vec_out word wr_idx and increments wr_idx. wr_idx is ceil(log2(N_WORDS)) bits and resets to 0.
    - Accept at wr_idx == N_WORDS-1 -> LAUNCH, wr_idx=0. If in_last=0 on this word, err_len pulses, but the frame still launches.
    - Accept with in_last=1 at wr_idx < N_WORDS-1 -> frame dropped: err_len pulses, wr_idx=0, stay in FILL. vec_out words already written are left stale, not cleared.
  - LAUNCH, one cycle: fc_start=1, busy=1, in_ready=0 -> WAIT, wait_cnt=0.
  - WAIT: fc_start=0, busy=1, in_ready=0, wait_cnt increments every cycle. When wait_cnt == FC_LATENCY-1 -> FILL with frame_done=1 for that cycle.
- vec_out is written only in FILL and is constant through LAUNCH and WAIT.
- in_valid during LAUNCH/WAIT is ignored; no data is lost because in_ready=0.
- Reset values: state=FILL, in_ready=1, vec_out=0, fc_start=0, busy=0, frame_done=0, err_len=0, wr_idx=0, wait_cnt=0.
- Reset mid-frame or mid-WAIT aborts immediately. Partial data is discarded (vec_out=0), and no frame_done is produced for the aborted frame.

## Timing
- Edge k accepts word N_WORDS-1. After edge k: fc_start=1, busy=1, in_ready=0, and vec_out holds the full frame.
- After edge k+1: fc_start=0, WAIT begins.
- After edge k+1+FC_LATENCY: frame_done=1, busy=0, in_ready=1, all in the same cycle.
- Minimum frame period = N_WORDS + FC_LATENCY + 1 cycles at full input rate.
- Gaps in in_valid only stall wr_idx; there is no timeout.
- err_len is asserted in the cycle after the offending accept edge.
- Simultaneous frame_done and in_valid: the word is accepted on that edge as index 0 of the next frame.

## Test plan
- Reset, then 120 back-to-back words 0x3F800000+j with in_last only on j=119:
  - vec_out word j = 0x3F800000+j.
  - fc_start high exactly 1 cycle, starting the cycle after the 120th accept.
  - With FC_LATENCY=16, frame_done high exactly 1 cycle, 17 cycles after fc_start rises.
- in_valid held high throughout WAIT with changing data -> no accepts and vec_out unchanged until frame_done.
- Frame with in_last on word 49 -> err_len single pulse, no fc_start. The following correct 120-word frame launches normally and its words overwrite indices 0..119.
- 120 words with in_last=0 everywhere -> err_len pulse coincident with fc_start; frame still launches.
- Random in_valid gaps (50% duty) across a 120-word frame -> same vec_out as the back-to-back case.
- reset asserted at wait_cnt=5, released 2 cycles later:
  - All outputs return to reset values asynchronously and in_ready=1.
  - No frame_done appears for the aborted frame.
  - The next full frame completes.

Source files
------------

// File: rtl/fc_input_collector_if.sv
// Feature-word stream into the FC input collector.
// One IEEE-754 word per valid/ready handshake.
interface fc_input_collector_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;

  modport master (
    output in_data,
    output in_valid,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/fc_input_collector.sv
// Collects a flattened feature frame into the FC input vector,
// launches the FC stage and times its fixed latency window.
module fc_input_collector #(
  parameter int DATA_WIDTH = 32,
  parameter int N_WORDS    = 120,
  parameter int FC_LATENCY = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  fc_input_collector_if.slave           inBus,
  output logic [N_WORDS*DATA_WIDTH-1:0] vec_out,
  output logic                          fc_start,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          err_len
);

  localparam int IW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int CW = (FC_LATENCY > 1) ? $clog2(FC_LATENCY) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_WORDS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(FC_LATENCY - 1);

  typedef enum logic [1:0] {
    FILL,
    LAUNCH,
    WAIT
  } state_t;

  state_t state;
  state_t stateD;

  logic [IW-1:0] wrIdx;
  logic [IW-1:0] wrIdxD;
  logic [CW-1:0] waitCnt;
  logic [CW-1:0] waitCntD;

  logic [N_WORDS-1:0][DATA_WIDTH-1:0] vecQ;

  logic accept;
  logic fcStartD;
  logic busyD;
  logic doneD;
  logic errD;

  assign inBus.in_ready = (state == FILL);
  assign accept  = inBus.in_valid && inBus.in_ready;
  assign vec_out = vecQ;

  always_comb begin
    stateD   = state;
    wrIdxD   = wrIdx;
    waitCntD = waitCnt;
    fcStartD = 1'b0;
    busyD    = 1'b0;
    doneD    = 1'b0;
    errD     = 1'b0;
    unique case (1'b1)
      (state == FILL): begin
        if (accept) begin
          // Full count launches even when in_last is missing.
          if (wrIdx == LAST_IDX) begin
            stateD   = LAUNCH;
            wrIdxD   = '0;
            fcStartD = 1'b1;
            busyD    = 1'b1;
            errD     = !inBus.in_last;
          end else if (inBus.in_last) begin
            wrIdxD = '0;
            errD   = 1'b1;
          end else begin
            wrIdxD = wrIdx + 1'b1;
          end
        end
      end
      (state == LAUNCH): begin
        stateD   = WAIT;
        waitCntD = '0;
        busyD    = 1'b1;
      end
      (state == WAIT): begin
        if (waitCnt == LAST_CNT) begin
          stateD   = FILL;
          waitCntD = '0;
          doneD    = 1'b1;
        end else begin
          waitCntD = waitCnt + 1'b1;
          busyD    = 1'b1;
        end
      end
      default: begin
        stateD = FILL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FILL;
      wrIdx      <= '0;
      waitCnt    <= '0;
      vecQ       <= '0;
      fc_start   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      state      <= stateD;
      wrIdx      <= wrIdxD;
      waitCnt    <= waitCntD;
      fc_start   <= fcStartD;
      busy       <= busyD;
      frame_done <= doneD;
      err_len    <= errD;
      if (accept) begin
        vecQ[wrIdx] <= inBus.in_data;
      end
    end
  end

endmodule

// File: tb/tb_fc_input_collector.sv
// Scoreboard bench for fc_input_collector with a short
// FC latency window; directed frames, drops and aborts.
module tb_fc_input_collector;

  localparam int DW = 32;
  localparam int N  = 120;
  localparam int L  = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fc_input_collector_if #(.DATA_WIDTH(DW)) bus ();

  logic [N*DW-1:0] vec_out;
  logic fc_start;
  logic busy;
  logic frame_done;
  logic err_len;

  fc_input_collector #(
    .DATA_WIDTH(DW),
    .N_WORDS(N),
    .FC_LATENCY(L)
  ) dut (
    .clk(clk),
    .reset(reset),
    .inBus(bus),
    .vec_out(vec_out),
    .fc_start(fc_start),
    .busy(busy),
    .frame_done(frame_done),
    .err_len(err_len)
  );

  typedef struct {
    int              cyc;
    logic            fs;
    logic            el;
    logic            fd;
    logic [N*DW-1:0] vec;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  logic [N-1:0][DW-1:0] model;
  int mIdx;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int firstDiff(
    input logic [N*DW-1:0] a,
    input logic [N*DW-1:0] b
  );
    for (int i = 0; i < N; i++) begin
      if (a[i*DW +: DW] !== b[i*DW +: DW]) return i;
    end
    return -1;
  endfunction

  // Monitor: every output pulse must match the head of the queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_event cyc=%0d got none required fs=%b el=%b fd=%b",
                 e.cyc, e.fs, e.el, e.fd);
      end
      if (fc_start || err_len || frame_done) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse cyc=%0d got fs=%b el=%b fd=%b required none",
                   cyc, fc_start, err_len, frame_done);
        end else begin
          e = sb.pop_front();
          if (e.cyc != cyc ||
              {fc_start, err_len, frame_done} !== {e.fs, e.el, e.fd}) begin
            errors++;
            $display("FAIL event cyc=%0d fs=%b el=%b fd=%b required cyc=%0d fs=%b el=%b fd=%b",
                     cyc, fc_start, err_len, frame_done,
                     e.cyc, e.fs, e.el, e.fd);
          end
          if (e.fs || e.fd) begin
            checks++;
            if (vec_out !== e.vec) begin
              int w;
              w = firstDiff(vec_out, e.vec);
              errors++;
              $display("FAIL vec_out cyc=%0d word %0d got %h required %h",
                       cyc, w, vec_out[w*DW +: DW], e.vec[w*DW +: DW]);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b required %b", name, act, exp);
    end
  endtask

  task automatic checkReset();
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_fc_start", fc_start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_err_len", err_len, 1'b0);
    checks++;
    if (vec_out !== '0) begin
      errors++;
      $display("FAIL rst_vec_out got nonzero required zero");
    end
  endtask

  task automatic modelAccept(input logic [DW-1:0] d, input logic last);
    exp_t x;
    model[mIdx] = d;
    if (mIdx == N - 1) begin
      x = '{cyc, 1'b1, !last, 1'b0, model};
      sb.push_back(x);
      x = '{cyc + 1 + L, 1'b0, 1'b0, 1'b1, model};
      sb.push_back(x);
      mIdx = 0;
    end else if (last) begin
      x = '{cyc, 1'b0, 1'b1, 1'b0, '0};
      sb.push_back(x);
      mIdx = 0;
    end else begin
      mIdx++;
    end
  endtask

  task automatic sendWord(input logic [DW-1:0] d, input logic last);
    int t;
    t = 0;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got in_ready=0 required 1 within 2000 cycles");
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    modelAccept(d, last);
  endtask

  task automatic sendFrame(
    input logic [DW-1:0] base,
    input int n,
    input int lastAt,
    input bit gaps
  );
    for (int j = 0; j < n; j++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      sendWord(base + DW'(j), j == lastAt);
    end
  endtask

  // Junk with in_valid high across the whole LAUNCH/WAIT window.
  task automatic holdJunk();
    bus.in_valid = 1'b1;
    for (int i = 0; i < L; i++) begin
      bus.in_data = $urandom;
      bus.in_last = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no finish required finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
    model        = '0;
    mIdx         = 0;
    repeat (3) @(posedge clk);
    #1;
    checkReset();
    reset = 1'b0;

    sendFrame(32'h3F80_0000, N, N - 1, 1'b0);
    holdJunk();
    chk("busy_in_wait", busy, 1'b1);
    chk("ready_in_wait", bus.in_ready, 1'b0);

    sendFrame(32'h4000_0000, 50, 49, 1'b0);
    sendFrame(32'h4040_0000, N, N - 1, 1'b0);

    sendFrame(32'h4100_0000, N, -1, 1'b0);

    sendFrame(32'h3F80_0000, N, N - 1, 1'b1);

    sendFrame(32'h4200_0000, N, N - 1, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    chk("busy_before_abort", busy, 1'b1);
    reset = 1'b1;
    #1;
    checkReset();
    sb.delete();
    model = '0;
    mIdx  = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    sendFrame(32'h4300_0000, N, N - 1, 1'b0);
    repeat (L + 6) @(posedge clk);
    #1;
    chk("ready_after_done", bus.in_ready, 1'b1);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
